// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared internal bus: registered one-hot grant plus select code.
// Optional macro BUS_ARB_HOLD_LIMIT_EN forces rotation after MAX_HOLD cycles under contention.
module bus_arbiter #(
  parameter int NUM_SRC  = 24,
  parameter int SEL_W    = 5,
  parameter int IDLE_SEL = 31,
  parameter int MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] BusReq,
  input  logic               BusLock,
  output logic [NUM_SRC-1:0] BusGrant,
  output logic [SEL_W-1:0]   BusSelect,
  output logic               BusValid,
  output logic               BusOwnerChange
);

  // state | meaning
  // IDLE  | no owner, bus select parked on IDLE_SEL
  // GRANT | source 'last' owns the bus
  typedef enum logic {IDLE, GRANT} state_t;

  if (NUM_SRC < 2 || NUM_SRC > 31) begin : g_bad_num_src
    $error("bus_arbiter: NUM_SRC must be in 2..31");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be in 1..15");
  end

  state_t             state;
  logic [SEL_W-1:0]   last;
  logic [NUM_SRC-1:0] cand;
  logic [SEL_W-1:0]   win;
  logic               found;
  logic [SEL_W:0]     sum;
  logic [SEL_W-1:0]   idx;
  logic               preempt;
  logic               keep;

  // The current owner is masked out, so in GRANT 'found' means another source is waiting.
  always_comb begin
    cand  = BusReq & ~BusGrant;
    win   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      sum = {1'b0, last} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(NUM_SRC)) sum = sum - (SEL_W+1)'(NUM_SRC);
      idx = sum[SEL_W-1:0];
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef BUS_ARB_HOLD_LIMIT_EN
  logic [3:0] hold;
  assign preempt = (hold >= 4'(MAX_HOLD-1)) && found;
`else
  assign preempt = 1'b0;
`endif

  assign keep = BusLock || (BusReq[last] && !preempt);

  always_ff @(posedge clock) begin
    if (!clear) begin
      state          <= IDLE;
      last           <= SEL_W'(NUM_SRC-1);
      BusGrant       <= '0;
      BusSelect      <= SEL_W'(IDLE_SEL);
      BusValid       <= 1'b0;
      BusOwnerChange <= 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold           <= '0;
`endif
    end else begin
      BusOwnerChange <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state          <= GRANT;
            last           <= win;
            BusGrant       <= NUM_SRC'(1) << win;
            BusSelect      <= win;
            BusValid       <= 1'b1;
            BusOwnerChange <= 1'b1;
`ifdef BUS_ARB_HOLD_LIMIT_EN
            hold           <= '0;
`endif
          end
        end
        GRANT: begin
          if (keep) begin
`ifdef BUS_ARB_HOLD_LIMIT_EN
            hold <= (hold == 4'd15) ? hold : hold + 4'd1;
`endif
          end else if (found) begin
            last           <= win;
            BusGrant       <= NUM_SRC'(1) << win;
            BusSelect      <= win;
            BusOwnerChange <= 1'b1;
`ifdef BUS_ARB_HOLD_LIMIT_EN
            hold           <= '0;
`endif
          end else begin
            state     <= IDLE;
            BusGrant  <= '0;
            BusSelect <= SEL_W'(IDLE_SEL);
            BusValid  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_onehot: assert property (@(posedge clock) disable iff (!clear) $onehot0(BusGrant));
  a_valid:  assert property (@(posedge clock) disable iff (!clear) BusValid == (|BusGrant));
  a_select: assert property (@(posedge clock) disable iff (!clear)
                             BusValid |-> ((BusSelect < SEL_W'(NUM_SRC)) && BusGrant[BusSelect]));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; expectations follow BUS_ARB_HOLD_LIMIT_EN.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] BusReq = '0;
  logic        BusLock = 1'b0;
  logic [23:0] BusGrant;
  logic [4:0]  BusSelect;
  logic        BusValid;
  logic        BusOwnerChange;

  int checks = 0;
  int failures = 0;

  bus_arbiter dut (
    .clock(clock), .clear(clear), .BusReq(BusReq), .BusLock(BusLock),
    .BusGrant(BusGrant), .BusSelect(BusSelect), .BusValid(BusValid),
    .BusOwnerChange(BusOwnerChange)
  );

  always #5 clock = ~clock;

  // {grant, select, valid, owner_change}
  wire [30:0] obs = {BusGrant, BusSelect, BusValid, BusOwnerChange};

  function automatic logic [30:0] owner(input int s, input logic oc);
    logic [23:0] g;
    g = 24'd1 << s;
    return {g, 5'(s), 1'b1, oc};
  endfunction

  function automatic logic [30:0] idle();
    return {24'd0, 5'd31, 1'b0, 1'b0};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; BusReq = 24'hFFFFFF; BusLock = 1'b0;
    step(); step();
    checks++;
    if (obs !== idle()) begin
      failures++; $display("FAIL reset_hold obs=%h required=%h", obs, idle());
    end
    clear = 1'b1;
    step();
    checks++;
    if (obs !== owner(0, 1'b1)) begin
      failures++; $display("FAIL reset_release obs=%h required=%h", obs, owner(0, 1'b1));
    end
    BusReq = '0;
    step();
    checks++;
    if (obs !== idle()) begin
      failures++; $display("FAIL reset_drop obs=%h required=%h", obs, idle());
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] reqs [6] = '{24'h300010, 24'h300000, 24'h200010,
                              24'h100010, 24'h300000, 24'h200010};
    int sels [6] = '{4, 20, 21, 4, 20, 21};
    for (int i = 0; i < 6; i++) begin
      BusReq = reqs[i];
      step();
      checks++;
      if (obs !== owner(sels[i], 1'b1)) begin
        failures++; $display("FAIL rr_%0d obs=%h required=%h", i, obs, owner(sels[i], 1'b1));
      end
    end
    BusReq = '0;
    step();
    checks++;
    if (obs !== idle()) begin
      failures++; $display("FAIL rr_idle obs=%h required=%h", obs, idle());
    end
  endtask

  task automatic test_wrap_idle();
    BusReq = 24'h800000;
    step();
    checks++;
    if (obs !== owner(23, 1'b1)) begin
      failures++; $display("FAIL wrap_23 obs=%h required=%h", obs, owner(23, 1'b1));
    end
    BusReq = 24'h000001;
    step();
    checks++;
    if (obs !== owner(0, 1'b1)) begin
      failures++; $display("FAIL wrap_0 obs=%h required=%h", obs, owner(0, 1'b1));
    end
    BusReq = '0;
    step();
    checks++;
    if (obs !== idle()) begin
      failures++; $display("FAIL wrap_idle obs=%h required=%h", obs, idle());
    end
  endtask

  task automatic test_lock();
    BusReq = 24'h200000;
    step();
    checks++;
    if (obs !== owner(21, 1'b1)) begin
      failures++; $display("FAIL lock_grant obs=%h required=%h", obs, owner(21, 1'b1));
    end
    BusLock = 1'b1; BusReq = 24'h100000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== owner(21, 1'b0)) begin
        failures++; $display("FAIL lock_keep_%0d obs=%h required=%h", i, obs, owner(21, 1'b0));
      end
    end
    BusLock = 1'b0;
    step();
    checks++;
    if (obs !== owner(20, 1'b1)) begin
      failures++; $display("FAIL lock_release obs=%h required=%h", obs, owner(20, 1'b1));
    end
    BusReq = '0;
    step();
    checks++;
    if (obs !== idle()) begin
      failures++; $display("FAIL lock_idle obs=%h required=%h", obs, idle());
    end
  endtask

  task automatic test_hold_limit();
    int   s;
    logic oc;
    BusReq = 24'h000028;
    for (int i = 0; i < 9; i++) begin
      step();
`ifdef BUS_ARB_HOLD_LIMIT_EN
      s  = (i < 4) ? 3 : ((i < 8) ? 5 : 3);
      oc = (i % 4) == 0;
`else
      s  = 3;
      oc = (i == 0);
`endif
      checks++;
      if (obs !== owner(s, oc)) begin
        failures++; $display("FAIL hold_%0d obs=%h required=%h", i, obs, owner(s, oc));
      end
    end
    BusReq = '0;
    step();
    checks++;
    if (obs !== idle()) begin
      failures++; $display("FAIL hold_idle obs=%h required=%h", obs, idle());
    end
  endtask

  task automatic test_back_to_back_reset();
    BusReq = 24'h010000;
    step();
    checks++;
    if (obs !== owner(16, 1'b1)) begin
      failures++; $display("FAIL mid_grant obs=%h required=%h", obs, owner(16, 1'b1));
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== owner(16, 1'b0)) begin
        failures++; $display("FAIL mid_keep_%0d obs=%h required=%h", i, obs, owner(16, 1'b0));
      end
    end
    clear = 1'b0;
    step();
    checks++;
    if (obs !== idle()) begin
      failures++; $display("FAIL mid_reset obs=%h required=%h", obs, idle());
    end
    clear = 1'b1;
    step();
    checks++;
    if (obs !== owner(16, 1'b1)) begin
      failures++; $display("FAIL mid_regrant obs=%h required=%h", obs, owner(16, 1'b1));
    end
    BusReq = '0;
    step();
    checks++;
    if (obs !== idle()) begin
      failures++; $display("FAIL mid_idle obs=%h required=%h", obs, idle());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap_idle();
    test_lock();
    test_hold_limit();
    test_back_to_back_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
